// File: rtl/amm_burst_mem_model.sv
// Avalon-MM burst slave memory with programmable read latency, optional LFSR stalls and sticky protocol-error flag.
// Optional macro AMM_MEM_ERR_INJECT_EN adds read-data bit-0 inversion at a chosen address.
module amm_burst_mem_model #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned BURST_W      = 4,
    parameter int unsigned READ_LAT     = 2,
    parameter int unsigned WAITREQ_MODE = 0,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  read_i,
    input  logic                  write_i,
    input  logic [ADDR_W-1:0]     address_i,
    input  logic [BURST_W-1:0]    burstcount_i,
    input  logic [DATA_W-1:0]     writedata_i,
    input  logic [DATA_W/8-1:0]   byteenable_i,
`ifdef AMM_MEM_ERR_INJECT_EN
    input  logic                  inj_en_i,
    input  logic [ADDR_W-1:0]     inj_addr_i,
`endif
    output logic                  waitrequest_o,
    output logic                  readdatavalid_o,
    output logic [DATA_W-1:0]     readdata_o,
    output logic                  err_o
);

    localparam int unsigned        NBYTES = DATA_W / 8;
    localparam logic [BURST_W-1:0] MAX_BC = BURST_W'(2 ** (BURST_W - 1));
    localparam logic [BURST_W-1:0] ONE    = BURST_W'(1);

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_WAIT, RD_DATA} state_t;

    state_t              state_q, state_d;
    logic                waitreq_q, waitreq_d;
    logic                rdv_q, rdv_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [BURST_W-1:0]  bc_q, bc_d;
    logic [BURST_W-1:0]  idx_q, idx_d;
    logic [3:0]          lat_q, lat_d;

    logic [DATA_W-1:0]   mem [2**ADDR_W];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   rd_word;
    logic                accept;
    logic                cmd_bad;
    logic                stall;

    assign accept  = (read_i | write_i) & ~waitreq_q;
    assign cmd_bad = (read_i & write_i) | (burstcount_i == '0) | (burstcount_i > MAX_BC);
    assign stall   = (WAITREQ_MODE == 1) && (lfsr_q[1:0] == 2'b00);
    assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign rd_addr = base_q + ADDR_W'(idx_q);

`ifdef AMM_MEM_ERR_INJECT_EN
    assign rd_word = mem[rd_addr] ^ {{(DATA_W-1){1'b0}}, (inj_en_i && (rd_addr == inj_addr_i))};
`else
    assign rd_word = mem[rd_addr];
`endif

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        bc_d      = bc_q;
        idx_d     = idx_q;
        lat_d     = lat_q;
        err_d     = err_q;
        rdv_d     = 1'b0;
        rdata_d   = rdata_q;
        mem_we    = 1'b0;
        mem_waddr = address_i;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else if (write_i) begin
                        mem_we = 1'b1;
                        base_d = address_i;
                        bc_d   = burstcount_i;
                        idx_d  = ONE;
                        if (burstcount_i != ONE) state_d = WR_BURST;
                    end else begin
                        base_d  = address_i;
                        bc_d    = burstcount_i;
                        idx_d   = '0;
                        lat_d   = 4'(READ_LAT - 1);
                        state_d = RD_WAIT;
                    end
                end
            end
            WR_BURST: begin
                if (read_i) err_d = 1'b1;
                if (write_i && !waitreq_q) begin
                    mem_we    = 1'b1;
                    mem_waddr = base_q + ADDR_W'(idx_q);
                    idx_d     = idx_q + ONE;
                    if (idx_q == bc_q - ONE) state_d = IDLE;
                end
            end
            RD_WAIT, RD_DATA: begin
                // lat_q counts remaining wait edges; beat 0 leaves on the edge where it reaches zero
                if (state_q == RD_WAIT && lat_q != '0) begin
                    lat_d = lat_q - 4'd1;
                end else begin
                    rdv_d   = 1'b1;
                    rdata_d = rd_word;
                    idx_d   = idx_q + ONE;
                    state_d = (idx_q == bc_q - ONE) ? IDLE : RD_DATA;
                end
            end
            default: state_d = IDLE;
        endcase
        waitreq_d = stall | rdv_d | (state_d inside {RD_WAIT, RD_DATA});
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            waitreq_q <= 1'b1;
            rdv_q     <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            lfsr_q    <= LFSR_SEED;
            base_q    <= '0;
            bc_q      <= '0;
            idx_q     <= '0;
            lat_q     <= '0;
        end else begin
            state_q   <= state_d;
            waitreq_q <= waitreq_d;
            rdv_q     <= rdv_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            lfsr_q    <= lfsr_d;
            base_q    <= base_d;
            bc_q      <= bc_d;
            idx_q     <= idx_d;
            lat_q     <= lat_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            for (int unsigned k = 0; k < NBYTES; k++) begin
                if (byteenable_i[k]) mem[mem_waddr][8*k +: 8] <= writedata_i[8*k +: 8];
            end
        end
    end

    assign waitrequest_o   = waitreq_q;
    assign readdatavalid_o = rdv_q;
    assign readdata_o      = rdata_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_amm_burst_mem_model.sv
// Directed bench for amm_burst_mem_model: one instance without and one with LFSR stalls, sharing stimulus.
module tb_amm_burst_mem_model;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd  = 1'b0;
    logic          wr  = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [BW-1:0] bc = '0;
    logic [DW-1:0] wd = '0;
    logic [3:0]    be = '0;

    logic          wq0, rdv0, err0;
    logic [DW-1:0] rdata0;
    logic          wq1, rdv1, err1;
    logic [DW-1:0] rdata1;

    int total = 0;
    int bad   = 0;
    int stalls = 0;

    logic [15:0] m_lfsr;
    logic        m_wq;

    always #5 clk = ~clk;

`ifdef AMM_MEM_ERR_INJECT_EN
    logic          inj_en = 1'b0;
    logic [AW-1:0] inj_addr = '0;
`endif

    amm_burst_mem_model #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .READ_LAT(RL),
                          .WAITREQ_MODE(0), .LFSR_SEED(16'hACE1)) u0 (
        .clk_i(clk), .rst_i(rst), .read_i(rd), .write_i(wr),
        .address_i(addr), .burstcount_i(bc), .writedata_i(wd), .byteenable_i(be),
`ifdef AMM_MEM_ERR_INJECT_EN
        .inj_en_i(inj_en), .inj_addr_i(inj_addr),
`endif
        .waitrequest_o(wq0), .readdatavalid_o(rdv0), .readdata_o(rdata0), .err_o(err0));

    amm_burst_mem_model #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .READ_LAT(RL),
                          .WAITREQ_MODE(1), .LFSR_SEED(16'hACE1)) u1 (
        .clk_i(clk), .rst_i(rst), .read_i(rd), .write_i(wr),
        .address_i(addr), .burstcount_i(bc), .writedata_i(wd), .byteenable_i(be),
`ifdef AMM_MEM_ERR_INJECT_EN
        .inj_en_i(inj_en), .inj_addr_i(inj_addr),
`endif
        .waitrequest_o(wq1), .readdatavalid_o(rdv1), .readdata_o(rdata1), .err_o(err1));

    // Reference stall generator: 16-bit Fibonacci LFSR, taps 16,14,13,11
    always @(posedge clk) begin
        if (rst) begin
            m_lfsr <= 16'hACE1;
            m_wq   <= 1'b1;
        end else begin
            m_wq   <= (m_lfsr[1:0] == 2'b00);
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic wq(input int s);
        return (s != 0) ? wq1 : wq0;
    endfunction

    function automatic logic rdv(input int s);
        return (s != 0) ? rdv1 : rdv0;
    endfunction

    function automatic logic [DW-1:0] rdat(input int s);
        return (s != 0) ? rdata1 : rdata0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wr_burst(input int s, input logic [AW-1:0] a, input int n,
                            input logic [DW-1:0] d0, input logic [3:0] b, input int chk);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            wr = 1'b1; addr = a; bc = BW'(n); wd = d0 + DW'(i); be = b;
            while (wq(s) && guard < 50) begin
                if (chk != 0) check("wq_lfsr", wq1, m_wq);
                stalls++;
                tick();
                guard++;
            end
            if (chk != 0) check("wq_lfsr", wq1, m_wq);
            check($sformatf("wr_ready_b%0d", i), wq(s), 1'b0);
            tick();
        end
        wr = 1'b0;
    endtask

    task automatic rd_burst(input int s, input logic [AW-1:0] a, input int n, input logic [DW-1:0] e0);
        int guard = 0;
        while (wq(s) && guard < 50) begin
            tick();
            guard++;
        end
        check("rd_ready", wq(s), 1'b0);
        rd = 1'b1; addr = a; bc = BW'(n);
        tick();
        rd = 1'b0;
        check("rd_wq_accept", wq(s), 1'b1);
        for (int k = 1; k < RL; k++) begin
            tick();
            check("rd_lat_rdv", rdv(s), 1'b0);
        end
        for (int i = 0; i < n; i++) begin
            tick();
            check($sformatf("rd_rdv_b%0d", i), rdv(s), 1'b1);
            check($sformatf("rd_data_a%0h_b%0d", a, i), rdat(s), e0 + DW'(i));
            check($sformatf("rd_wq_b%0d", i), wq(s), 1'b1);
        end
        tick();
        check("rd_end_rdv", rdv(s), 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        check("rst_wq", wq0, 1'b1);
        check("rst_rdv", rdv0, 1'b0);
        check("rst_rdata", rdata0, 32'h0);
        check("rst_err", err0, 1'b0);
        rst = 1'b0;
        tick();
        check("rst_release_wq", wq0, 1'b0);

        wr_burst(0, 10'h010, 4, 32'hA0, 4'hF, 0);
        rd_burst(0, 10'h010, 4, 32'hA0);

        wr_burst(0, 10'h020, 1, 32'hFFFF_FFFF, 4'hF, 0);
        wr_burst(0, 10'h020, 1, 32'h1234_5678, 4'b0101, 0);
        rd_burst(0, 10'h020, 1, 32'hFF34_FF78);

        wr_burst(0, 10'h3FE, 4, 32'hB0, 4'hF, 0);
        rd_burst(0, 10'h000, 2, 32'hB2);
        rd_burst(0, 10'h3FE, 2, 32'hB0);
        check("err_clean", err0, 1'b0);

        // burstcount 0, burstcount 9, read+write together
        for (int c = 0; c < 3; c++) begin
            do_reset();
            check("err_after_rst", err0, 1'b0);
            rd = (c == 2); wr = 1'b1; addr = AW'(16 + c);
            bc = (c == 0) ? BW'(0) : (c == 1) ? BW'(9) : BW'(1);
            wd = 32'hDEAD_BEEF; be = 4'hF;
            tick();
            rd = 1'b0; wr = 1'b0;
            check($sformatf("err_set_c%0d", c), err0, 1'b1);
            rd_burst(0, AW'(16 + c), 1, 32'hA0 + DW'(c));
            check($sformatf("err_sticky_c%0d", c), err0, 1'b1);
        end

        do_reset();
        rd = 1'b1; addr = 10'h010; bc = BW'(4);
        tick();
        rd = 1'b0;
        for (int k = 1; k < RL; k++) tick();
        tick();
        check("abort_b0", rdata0, 32'hA0);
        tick();
        check("abort_b1_rdv", rdv0, 1'b1);
        check("abort_b1", rdata0, 32'hA1);
        rst = 1'b1;
        tick();
        check("abort_rdv", rdv0, 1'b0);
        check("abort_wq", wq0, 1'b1);
        rst = 1'b0;
        tick();
        check("abort_release_wq", wq0, 1'b0);
        rd_burst(0, 10'h013, 1, 32'hA3);

        do_reset();
        stalls = 0;
        wr_burst(1, 10'h100, 8, 32'hC0, 4'hF, 1);
        check("lfsr_stall_seen", (stalls != 0), 1'b1);
        rd_burst(1, 10'h100, 8, 32'hC0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
